bit_stuff: RTL and testbench
============================

Name: bit_stuff

Overview:
- Serial bit stuffer that sits directly upstream of the NRZI encoder.
- Takes the raw serial packet bitstream (SYNC, PID, payload, CRC) from the serializer, one bit per clock.
- Inserts a 0 after every STUFF_LEN consecutive 1s and presents the stuffed stream on s_out.
- Generates the start_nrzi and done strobes the NRZI stage consumes, and stalls the serializer with pause while a stuff bit is inserted.

Parameters:
STUFF_LEN, 6, number of consecutive 1s after which a 0 is inserted; legal range 2..15.

Ports:
clk  input  1  single system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
start_stuff  input  1  one-cycle pulse; first packet bit is on s_in in the following cycle.
s_in  input  1  serial data bit from serializer; consumed every RUN cycle that pause is low.
in_last  input  1  high together with the final packet bit on s_in.
pause  output  1  combinational; high means s_in/in_last are not consumed this cycle and upstream must hold them.
s_out  output  1  registered stuffed bitstream to the NRZI stage.
start_nrzi  output  1  registered one-cycle pulse to the NRZI stage at packet start.
done  output  1  registered one-cycle pulse to the NRZI stage at packet end.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - s_out=0, start_nrzi=0, done=0, ones count=0.
  - pause=0 and busy=0 follow from state.
  - Reset mid-packet aborts immediately; no done pulse is issued.
- FSM states: IDLE, RUN, STUFF, LAST_STUFF, FIN.
- IDLE:
  - On start_stuff go to RUN, register start_nrzi=1 for exactly the next cycle, and clear ones count.
  - s_out holds its last value.
  - in_last and s_in are ignored.
- RUN (each cycle one bit is consumed):
  - s_out <= s_in.
  - If s_in=1, cnt_next = cnt+1; else cnt_next = 0.
  - If cnt_next == STUFF_LEN:
    - in_last=0: go to STUFF.
    - in_last=1: go to LAST_STUFF.
  - Else if in_last=1: go to FIN. done registers high for one cycle, coincident with the final bit being on s_out.
  - Else stay in RUN.
- STUFF:
  - pause=1; s_out <= 0; cnt <= 0; return to RUN.
  - The stuffed 0 counts as a zero for the next run of 1s.
- LAST_STUFF:
  - pause=1; s_out <= 0; cnt <= 0; go to FIN.
  - done registers high, coincident with the stuff bit on s_out.
- FIN: one cycle, then return to IDLE. done is high during FIN.
- Latency: s_out shows a consumed bit one cycle after the cycle it is consumed on s_in.
- Stuff bit insertion: one extra cycle per stuff bit. Upstream sees pause for exactly that cycle.
- start_stuff while busy is ignored; there is no queuing.
- A single-bit packet (in_last with the first bit) is legal.
- Back-to-back packets: start_stuff may be asserted in the FIN cycle. It is accepted and the block re-enters RUN next cycle.
- The ones counter is $clog2(STUFF_LEN+1) bits and is never allowed to exceed STUFF_LEN.
- Stuffing applies to every bit from the first consumed bit, SYNC included.

Decomposition:
- Shared package usb_pkg holds:
  - the stuffer state enum (stuff_state_t: IDLE, RUN, STUFF, LAST_STUFF, FIN);
  - the constant USB_STUFF_LEN = 6 used as the STUFF_LEN default.
- One sub-module, bit_stuff_fsm, owns:
  - state, the ones counter compare, pause, busy;
  - start_nrzi/done generation.
- The top level keeps the s_out register and the ones counter datapath.

Test Plan:
- Reset mid-packet: rst asserted during RUN -> next cycle busy=0, s_out=0, no done pulse. A following start_stuff works normally.
- SYNC+PID 00000001_11000011, in_last on the final bit:
  - s_out matches the input delayed 1 cycle, with no pause.
  - start_nrzi is high exactly 1 cycle after start_stuff.
  - done is high with the final 1 on s_out.
- Payload 01111110 (six 1s):
  - pause is high for exactly one cycle after the sixth 1.
  - s_out is 011111100 (9 bits); the inserted 0 follows the sixth 1.
- Twelve consecutive 1s, then last: two pause cycles, output 1111110111111 + 0 (stuff bits at positions 7 and 14). done is coincident with the second stuff bit (LAST_STUFF path).
- Five 1s then 0, then five 1s: no pause ever, output equals input; this checks the counter clears on 0.
- Back-to-back: start_stuff asserted in the FIN cycle of packet 1 -> packet 2 starts with start_nrzi the next cycle. start_stuff pulsed during RUN is ignored (no second start_nrzi).

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB serial-path types: bit-stuffer state encoding and default stuff length.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STUFF,
    ST_LAST_STUFF,
    ST_FIN
  } stuff_state_t;

  localparam int USB_STUFF_LEN = 6;

  // Ones-counter width able to hold the value len itself.
  function automatic int ones_cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/bit_stuff_if.sv
// Serializer-side handshake and NRZI-side strobes of the bit stuffer.
interface bit_stuff_if;
  logic start_stuff;
  logic s_in;
  logic in_last;
  logic pause;
  logic s_out;
  logic start_nrzi;
  logic done;
  logic busy;

  modport master (
    output start_stuff, s_in, in_last,
    input  pause, s_out, start_nrzi, done, busy
  );

  modport slave (
    input  start_stuff, s_in, in_last,
    output pause, s_out, start_nrzi, done, busy
  );
endinterface

// File: rtl/bit_stuff_fsm.sv
// Bit-stuffer control: packet sequencing, stuff decision, pause/busy and NRZI strobes.
module bit_stuff_fsm
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN,
  parameter int CW        = ones_cnt_w(STUFF_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          last_i,
  input  logic [CW-1:0] cnt_next_i,
  output logic          consume_o,
  output logic          stuff_o,
  output logic          cnt_clr_o,
  output logic          pause_o,
  output logic          busy_o,
  output logic          start_nrzi_o,
  output logic          done_o
);

  stuff_state_t state_q, state_d;
  logic         start_nrzi_q, start_nrzi_d;
  logic         done_q, done_d;
  logic         hit;

  assign hit = (cnt_next_i == CW'(STUFF_LEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_nrzi_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_nrzi_q <= start_nrzi_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    consume_o    = 1'b0;
    stuff_o      = 1'b0;
    cnt_clr_o    = 1'b0;
    pause_o      = 1'b0;
    start_nrzi_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_RUN;
          start_nrzi_d = 1'b1;
          cnt_clr_o    = 1'b1;
        end
      end
      ST_RUN: begin
        consume_o = 1'b1;
        if (hit) begin
          state_d = last_i ? ST_LAST_STUFF : ST_STUFF;
        end else if (last_i) begin
          state_d = ST_FIN;
        end
      end
      ST_STUFF: begin
        pause_o   = 1'b1;
        stuff_o   = 1'b1;
        cnt_clr_o = 1'b1;
        state_d   = ST_RUN;
      end
      ST_LAST_STUFF: begin
        pause_o   = 1'b1;
        stuff_o   = 1'b1;
        cnt_clr_o = 1'b1;
        state_d   = ST_FIN;
      end
      ST_FIN: begin
        // A new packet may be accepted in the closing cycle of the previous one.
        if (start_i) begin
          state_d      = ST_RUN;
          start_nrzi_d = 1'b1;
          cnt_clr_o    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_FIN);
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign start_nrzi_o = start_nrzi_q;
  assign done_o       = done_q;

endmodule

// File: rtl/bit_stuff.sv
// Serial bit stuffer: inserts a 0 after STUFF_LEN consecutive 1s ahead of the NRZI encoder.
module bit_stuff
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic        clk,
  input  logic        rst,
  bit_stuff_if.slave  stuff_if
);

  localparam int CW = ones_cnt_w(STUFF_LEN);

  if (STUFF_LEN < 2 || STUFF_LEN > 15) begin : g_bad_len
    $error("bit_stuff: STUFF_LEN must be within 2..15");
  end

  logic [CW-1:0] cnt_q, cnt_d, cnt_next;
  logic          s_out_q, s_out_d;
  logic          consume, stuff, cnt_clr;

  // The counter peaks at STUFF_LEN for one cycle; the stuff state then clears it.
  assign cnt_next = stuff_if.s_in ? (cnt_q + CW'(1)) : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (consume) begin
      cnt_d = cnt_next;
    end
  end

  always_comb begin
    s_out_d = s_out_q;
    if (consume) begin
      s_out_d = stuff_if.s_in;
    end else if (stuff) begin
      s_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      s_out_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      s_out_q <= s_out_d;
    end
  end

  bit_stuff_fsm #(
    .STUFF_LEN (STUFF_LEN),
    .CW        (CW)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .start_i      (stuff_if.start_stuff),
    .last_i       (stuff_if.in_last),
    .cnt_next_i   (cnt_next),
    .consume_o    (consume),
    .stuff_o      (stuff),
    .cnt_clr_o    (cnt_clr),
    .pause_o      (stuff_if.pause),
    .busy_o       (stuff_if.busy),
    .start_nrzi_o (stuff_if.start_nrzi),
    .done_o       (stuff_if.done)
  );

  assign stuff_if.s_out = s_out_q;

endmodule

// File: tb/tb_bit_stuff.sv
// Directed self-checking bench for bit_stuff with hand-computed stuffed streams.
module tb_bit_stuff;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic last_out;

  bit_stuff_if bif ();

  bit_stuff #(.STUFF_LEN(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .stuff_if (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic do_start(input string tag);
    bif.start_stuff = 1'b1;
    bif.s_in        = 1'b0;
    bif.in_last     = 1'b0;
    tick();
    chk({tag, "_start_nrzi"}, bif.start_nrzi, 1'b1);
    chk({tag, "_start_busy"}, bif.busy, 1'b1);
    chk({tag, "_start_pause"}, bif.pause, 1'b0);
    chk({tag, "_start_sout_hold"}, bif.s_out, last_out);
    $display("%s start: start_nrzi=%0b busy=%0b", tag, bif.start_nrzi, bif.busy);
  endtask

  // Feeds in_s one bit per consumed cycle and checks the stuffed stream exp_s.
  // msk_s marks which output positions are inserted stuff bits.
  task automatic run_body(input string tag, input string in_s, input string exp_s,
                          input string msk_s, input bit chain, input int glitch_at);
    int idx;
    int n_in;
    int n_out;
    logic exp_pause;
    idx   = 0;
    n_in  = in_s.len();
    n_out = exp_s.len();
    for (int j = 0; j < n_out; j++) begin
      bif.start_stuff = (j == glitch_at);
      if (idx < n_in) begin
        bif.s_in    = (in_s[idx] == "1");
        bif.in_last = (idx == n_in - 1);
      end
      tick();
      exp_pause = (j + 1 < n_out) ? (msk_s[j + 1] == "1") : 1'b0;
      chk($sformatf("%s_sout%0d", tag, j), bif.s_out, exp_s[j] == "1");
      chk($sformatf("%s_pause%0d", tag, j), bif.pause, exp_pause);
      chk($sformatf("%s_done%0d", tag, j), bif.done, j == n_out - 1);
      chk($sformatf("%s_snrzi%0d", tag, j), bif.start_nrzi, 1'b0);
      chk($sformatf("%s_busy%0d", tag, j), bif.busy, 1'b1);
      $display("%s cyc%0d: s_out=%0b pause=%0b done=%0b", tag, j, bif.s_out, bif.pause, bif.done);
      if (msk_s[j] != "1") idx++;
    end
    last_out        = (exp_s[n_out - 1] == "1");
    bif.s_in        = 1'b0;
    bif.in_last     = 1'b0;
    bif.start_stuff = chain;
    tick();
    if (chain) begin
      chk({tag, "_chain_snrzi"}, bif.start_nrzi, 1'b1);
      chk({tag, "_chain_busy"}, bif.busy, 1'b1);
      chk({tag, "_chain_done"}, bif.done, 1'b0);
    end else begin
      chk({tag, "_end_busy"}, bif.busy, 1'b0);
      chk({tag, "_end_done"}, bif.done, 1'b0);
      chk({tag, "_end_pause"}, bif.pause, 1'b0);
      chk({tag, "_end_sout_hold"}, bif.s_out, last_out);
    end
    $display("%s end: busy=%0b start_nrzi=%0b", tag, bif.busy, bif.start_nrzi);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    last_out        = 1'b0;
    rst             = 1'b1;
    bif.start_stuff = 1'b0;
    bif.s_in        = 1'b0;
    bif.in_last     = 1'b0;
    tick();
    tick();
    chk("rst_busy", bif.busy, 1'b0);
    chk("rst_sout", bif.s_out, 1'b0);
    chk("rst_pause", bif.pause, 1'b0);
    chk("rst_done", bif.done, 1'b0);
    chk("rst_snrzi", bif.start_nrzi, 1'b0);
    $display("reset: busy=%0b s_out=%0b", bif.busy, bif.s_out);
    rst = 1'b0;
    tick();

    // Abort mid-packet with reset
    do_start("abort");
    bif.start_stuff = 1'b0;
    bif.s_in        = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_run_busy%0d", k), bif.busy, 1'b1);
      chk($sformatf("abort_run_sout%0d", k), bif.s_out, 1'b1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.s_in = 1'b0;
    chk("abort_busy", bif.busy, 1'b0);
    chk("abort_sout", bif.s_out, 1'b0);
    chk("abort_done", bif.done, 1'b0);
    chk("abort_pause", bif.pause, 1'b0);
    $display("abort: busy=%0b s_out=%0b done=%0b", bif.busy, bif.s_out, bif.done);
    last_out = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("abort_idle_done%0d", k), bif.done, 1'b0);
      chk($sformatf("abort_idle_busy%0d", k), bif.busy, 1'b0);
    end

    do_start("sync");
    run_body("sync", "0000000111000011", "0000000111000011", "0000000000000000", 1'b0, -1);

    do_start("six");
    run_body("six", "01111110", "011111100", "000000010", 1'b0, -1);

    do_start("twelve");
    run_body("twelve", "111111111111", "11111101111110", "00000010000001", 1'b0, -1);

    do_start("five");
    run_body("five", "11111011111", "11111011111", "00000000000", 1'b0, -1);

    do_start("single");
    run_body("single", "1", "1", "0", 1'b0, -1);

    do_start("b2b1");
    run_body("b2b1", "1011", "1011", "0000", 1'b1, 2);
    run_body("b2b2", "0110", "0110", "0000", 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
